// File: rtl/wide_add_seq_if.sv
// Request/response bundle between a datapath and the wide_add_seq sequencer.
// Optional `ovf` signal is present when WIDE_ADD_SEQ_OVF_EN is defined.
`timescale 1ns/1ps
interface wide_add_seq_if #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
);
    localparam int N = WIDTH * WORDS;

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         c_out;
`ifdef WIDE_ADD_SEQ_OVF_EN
    logic         ovf;

    modport master (output start, a, b, c_in, input busy, done, s, c_out, ovf);
    modport slave  (input start, a, b, c_in, output busy, done, s, c_out, ovf);
`else
    modport master (output start, a, b, c_in, input busy, done, s, c_out);
    modport slave  (input start, a, b, c_in, output busy, done, s, c_out);
`endif
endinterface

// File: rtl/wide_add_seq.sv
// Word-serial WORDS x WIDTH-bit adder sequencer driving one shared ripple adder.
// Define WIDE_ADD_SEQ_OVF_EN to add the two's-complement overflow output.
`timescale 1ns/1ps
module wide_add_seq #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    wide_add_seq_if.slave    bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout
);
    localparam int N     = WIDTH * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     a_sh_q, a_sh_d;
    logic [N-1:0]     b_sh_q, b_sh_d;
    logic [N-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef WIDE_ADD_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Operands are shifted right so the current word always sits in the low bits.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_sh_q[WIDTH-1:0];
            add_b   = b_sh_q[WIDTH-1:0];
            add_cin = carry_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.c_in;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) sum_d[w*WIDTH +: WIDTH] = add_s;
                end
                carry_d = add_cout;
                a_sh_d  = a_sh_q >> WIDTH;
                b_sh_d  = b_sh_q >> WIDTH;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = add_cout;
`ifdef WIDE_ADD_SEQ_OVF_EN
                    // Carry into the sign bit recovered from the sign bits of a, b and s.
                    ovf_d   = (add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_s[WIDTH-1]) ^ add_cout;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef WIDE_ADD_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef WIDE_ADD_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.s     = sum_q;
    assign bus.c_out = cout_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
    assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq with a behavioural ripple adder beside it.
// Overflow checks are included when WIDE_ADD_SEQ_OVF_EN is defined.
`timescale 1ns/1ps
module tb_wide_add_seq;
    localparam int WIDTH = 4;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] add_a, add_b, add_s;
    logic             add_cin, add_cout;

    always #5 clk = ~clk;

    wide_add_seq_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    wide_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // Shared combinational adder the sequencer drives.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   busy_len = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every done pulse and checks run length.
    always @(negedge clk) begin
        if (rst) begin
            busy_len  = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.busy) busy_len++;
            if (bus.done) begin
                check("done_single_cycle", N'(prev_done), '0);
                check("busy_cycles", N'(busy_len), N'(WORDS));
                busy_len = 0;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got s=%h with no request outstanding", bus.s);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sum", bus.s, mon_e.s);
                    check("c_out", N'(bus.c_out), N'(mon_e.c));
`ifdef WIDE_ADD_SEQ_OVF_EN
                    check("ovf", N'(bus.ovf), N'(mon_e.v));
`endif
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no done within 20 cycles, required one", name);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] a_seq;
        logic [N-1:0] b_seq;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", N'(bus.busy), '0);
        check("rst_done", N'(bus.done), '0);
        check("rst_s", bus.s, '0);
        check("rst_c_out", N'(bus.c_out), '0);
        check("rst_add_a", N'(add_a), '0);
        check("rst_add_b", N'(add_b), '0);
        check("rst_add_cin", N'(add_cin), '0);
`ifdef WIDE_ADD_SEQ_OVF_EN
        check("rst_ovf", N'(bus.ovf), '0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full carry ripple through every word.
        exp_q.push_back('{s: 16'h0000, c: 1'b1, v: 1'b0});
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done("ffff_plus_1");

        // Word order on the adder port, least significant word first.
        exp_q.push_back('{s: 16'h5556, c: 1'b0, v: 1'b0});
        issue(16'h1234, 16'h4321, 1'b1);
        a_seq = 16'h1234;
        b_seq = 16'h4321;
        for (int w = 0; w < WORDS; w++) begin
            check("add_a_word", N'(add_a), N'(a_seq[w*WIDTH +: WIDTH]));
            check("add_b_word", N'(add_b), N'(b_seq[w*WIDTH +: WIDTH]));
            if (w < WORDS - 1) begin
                @(posedge clk);
                #1;
            end
        end
        wait_done("seq_1234");
        repeat (2) @(posedge clk);
        #1;
        check("s_hold_idle", bus.s, 16'h5556);

        // start during RUN must be ignored.
        exp_q.push_back('{s: 16'h3333, c: 1'b0, v: 1'b0});
        issue(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        issue(16'hAAAA, 16'h5555, 1'b0);
        wait_done("ignored_start");
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back: start held through DONE.
        exp_q.push_back('{s: 16'h0003, c: 1'b0, v: 1'b0});
        exp_q.push_back('{s: 16'h1000, c: 1'b0, v: 1'b0});
        bus.a     = 16'h0001;
        bus.b     = 16'h0002;
        bus.c_in  = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 16'h0F0F;
        bus.b = 16'h00F1;
        wait_done("b2b_first");
        check("b2b_no_idle", N'(bus.busy), N'(1));
        bus.start = 1'b0;
        wait_done("b2b_second");
        repeat (2) @(posedge clk);
        #1;

        // Reset on the third RUN cycle discards the operation.
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstrun_busy", N'(bus.busy), '0);
        check("rstrun_done", N'(bus.done), '0);
        check("rstrun_s", bus.s, '0);
        check("rstrun_c_out", N'(bus.c_out), '0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;

`ifdef WIDE_ADD_SEQ_OVF_EN
        exp_q.push_back('{s: 16'h8000, c: 1'b0, v: 1'b1});
        issue(16'h7FFF, 16'h0001, 1'b0);
        wait_done("ovf_pos");
        exp_q.push_back('{s: 16'h0000, c: 1'b1, v: 1'b1});
        issue(16'h8000, 16'h8000, 1'b0);
        wait_done("ovf_neg");
        exp_q.push_back('{s: 16'h0000, c: 1'b1, v: 1'b0});
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done("ovf_none");
`endif

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle sequencer that performs a WORDS×WIDTH-bit addition using one shared WIDTH-bit combinational ripple-carry adder instantiated beside it. It accepts a wide operand pair on `start` and feeds the adder one word per cycle, least-significant word first. It chains the carry through a register and assembles the wide sum. It sits between a requesting datapath and the existing `adder` instance, which it drives directly.

## Interface
- WIDTH, 4, bit width of the shared adder (word size)
- WORDS, 4, number of words per operand; total width N = WIDTH*WORDS
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE or DONE
- a  in  N  operand A, sampled on accepting edge
- b  in  N  operand B, sampled on accepting edge
- c_in  in  1  carry into word 0, sampled on accepting edge
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE
- s  out  N  wide sum, valid from done until the next accepting edge
- c_out  out  1  carry out of the top word, valid with s
- add_a  out  WIDTH  to adder `a`
- add_b  out  WIDTH  to adder `b`
- add_cin  out  1  to adder `c_in`
- add_s  in  WIDTH  from adder `s`
- add_cout  in  1  from adder `c_out`

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `start`=1 → RUN. On that edge:
  - load operand shift registers from a/b;
  - carry reg ← c_in;
  - word index ← 0.
- RUN: add_a/add_b = word[index] of the captured operands, add_cin = carry reg (combinational from registers). Each edge:
  - sum word[index] ← add_s;
  - carry reg ← add_cout;
  - index += 1.
- RUN → DONE on the edge where index == WORDS-1.
- DONE: done=1, s = assembled sum, c_out = carry reg. Next edge:
  - `start`=1 → load new operands, go to RUN (back-to-back);
  - else → IDLE.
- `start` in RUN is ignored; no queuing.
- In IDLE, add_a/add_b/add_cin = 0.
- s/c_out hold their last result through IDLE. They change only when words are written during a new RUN.
- The sum is modulo 2^N; c_out is the true carry out of bit N-1.
- Index width is clog2(WORDS), minimum 1. WORDS=1 is legal: single-cycle RUN.

## Timing
- Reset values: state=IDLE, busy=0, done=0, s=0, c_out=0, add_a=0, add_b=0, add_cin=0, index=0, carry reg=0.
- Latency: start accepted at edge T → busy high from T to T+WORDS → done high for exactly the cycle after edge T+WORDS.
- Throughput: one operation per WORDS+1 cycles.
- rst during RUN/DONE: immediate return to IDLE with all reset values. The partial sum is discarded, and no done pulse is issued.
- rst and start together: rst wins.
- add_s/add_cout must settle within one cycle; there is no adder pipelining.

## Configuration
- `WIDE_ADD_SEQ_OVF_EN` defined: adds output `ovf` (out, 1), two's-complement overflow of the N-bit add.
  - Computed on the final word: ovf = carry into bit N-1 XOR add_cout.
  - Carry into bit N-1 = a_msb ^ b_msb ^ s_msb.
  - Registered with c_out; reset 0; held like s.
- Undefined: port `ovf` and its logic are absent.

## Test plan
- WIDTH=4, WORDS=4: start with a=16'hFFFF, b=16'h0001, c_in=0 → busy 4 cycles, done pulse 1 cycle, s=16'h0000, c_out=1.
- a=16'h1234, b=16'h4321, c_in=1 → s=16'h5556, c_out=0. Check add_a sequence is 4,3,2,1 on consecutive cycles.
- Pulse start again 2 cycles into RUN with different operands → ignored; result and timing equal the first request.
- Assert rst on 3rd RUN cycle → next cycle busy=0, done=0, s=0, c_out=0. No done pulse follows.
- Hold start high through DONE with a=16'h0F0F, b=16'h00F1 → RUN re-entered with no IDLE cycle. Second done gives s=16'h1000, c_out=0.
- `WIDE_ADD_SEQ_OVF_EN` defined:
  - 16'h7FFF+16'h0001 → s=16'h8000, c_out=0, ovf=1;
  - 16'h8000+16'h8000 → s=0, c_out=1, ovf=1;
  - 16'hFFFF+16'h0001 → ovf=0.
